// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle 16-bit RISC core: sequences fetch/decode/execute/memory/write-back.
// Optional retired-instruction counter is enabled by defining PERF_CNT_EN.
module multicycle_main_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             branch_ne,
    output logic [1:0]       pc_src,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             csig,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_EXEC_R    = 4'd2;
    localparam logic [3:0] S_EXEC_I    = 4'd3;
    localparam logic [3:0] S_WB_ALU    = 4'd4;
    localparam logic [3:0] S_MEM_ADDR  = 4'd5;
    localparam logic [3:0] S_MEM_READ  = 4'd6;
    localparam logic [3:0] S_MEM_WB    = 4'd7;
    localparam logic [3:0] S_MEM_WRITE = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JUMP      = 4'd10;
    localparam logic [3:0] S_HALT      = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       r_halted;
    logic       r_illegal;
    logic       w_set_illegal;
    logic       w_retire;

    always_comb begin
        w_next        = S_FETCH;
        w_set_illegal = 1'b0;
        case (r_state)
            S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    4'b0000:                   w_next = S_EXEC_R;
                    4'b0001, 4'b0010, 4'b0011,
                    4'b0100, 4'b0101, 4'b0110,
                    4'b0111:                   w_next = S_EXEC_I;
                    4'b1000, 4'b1001:          w_next = S_MEM_ADDR;
                    4'b1010, 4'b1011:          w_next = S_BRANCH;
                    4'b1100:                   w_next = S_JUMP;
                    4'b1111:                   w_next = S_HALT;
                    default: begin
                        w_next        = S_HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            S_EXEC_R:    w_next = S_WB_ALU;
            S_EXEC_I:    w_next = S_WB_ALU;
            S_WB_ALU:    w_next = S_FETCH;
            S_MEM_ADDR:  w_next = op[0] ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_BRANCH:    w_next = S_FETCH;
            S_JUMP:      w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT)
                r_halted <= 1'b1;
            if (w_set_illegal)
                r_illegal <= 1'b1;
        end
    end

    // Raw Moore decode; every strobe is gated with rst_n below so reset kills requests at once.
    logic       w_pc_write, w_pc_write_cond, w_branch_ne, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_ir_write, w_reg_write, w_mem_to_reg, w_reg_dst, w_alu_src_a, w_csig;
    logic [1:0] w_pc_src, w_alu_src_b;

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_branch_ne     = 1'b0;
        w_pc_src        = 2'b00;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_csig          = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_csig      = 1'b1;
                w_ir_write  = mem_ready;
                w_pc_write  = mem_ready;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                w_csig      = 1'b1;
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
            end
            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_WB_ALU: begin
                w_reg_write = 1'b1;
                w_reg_dst   = (op == 4'b0000);
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_csig      = 1'b1;
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_pc_write_cond = 1'b1;
                w_pc_src        = 2'b01;
                w_branch_ne     = op[0];
            end
            S_JUMP: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b10;
            end
            default: ;
        endcase
    end

    assign pc_write      = w_pc_write & rst_n;
    assign pc_write_cond = w_pc_write_cond & rst_n;
    assign branch_ne     = w_branch_ne & rst_n;
    assign pc_src        = w_pc_src & {2{rst_n}};
    assign i_or_d        = w_i_or_d & rst_n;
    assign mem_read      = w_mem_read & rst_n;
    assign mem_write     = w_mem_write & rst_n;
    assign ir_write      = w_ir_write & rst_n;
    assign reg_write     = w_reg_write & rst_n;
    assign mem_to_reg    = w_mem_to_reg & rst_n;
    assign reg_dst       = w_reg_dst & rst_n;
    assign alu_src_a     = w_alu_src_a & rst_n;
    assign alu_src_b     = w_alu_src_b & {2{rst_n}};
    assign csig          = w_csig & rst_n;
    assign halted        = r_halted;
    assign illegal_op    = r_illegal;

    // An instruction retires when a completing state hands control back to FETCH.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_WB_ALU) || (r_state == S_MEM_WB) ||
                       (r_state == S_MEM_WRITE) || (r_state == S_BRANCH) ||
                       (r_state == S_JUMP));

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if (w_retire && (r_count != {CNT_W{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign instr_count = r_count;
`else
    logic w_unused_retire;
    assign w_unused_retire = w_retire;
    assign instr_count     = '0;
`endif

endmodule
